// File: rtl/arb_mux_4_1.sv
// Round-robin arbiter feeding a 4:1 word select into a single registered output slot.
// Downstream backpressure is applied through the out_valid/out_ready handshake.
module arb_mux_4_1 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    logic [1:0]       ptr;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             found;
    logic             can_load;
    logic             load;
    logic [WIDTH-1:0] sel_data;

    // Scan from the priority pointer; the first requester seen wins.
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign can_load = !out_valid || out_ready;
    assign load     = can_load && found && !rst;
    assign gnt      = load ? (4'b0001 << win) : 4'b0000;

    // Select is driven only by the winner index, so a losing requester's data never reaches the slot.
    always_comb begin
        sel_data = d0;
        case (win)
            2'd1:    sel_data = d1;
            2'd2:    sel_data = d2;
            2'd3:    sel_data = d3;
            default: sel_data = d0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
        end else if (load) begin
            ptr       <= win + 2'd1;
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= win;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux_4_1.sv
// Self-checking bench for arb_mux_4_1: expected words are queued when a grant is
// expected and popped when the output slot should hold them.
module tb_arb_mux_4_1;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [1:0]       sel;
        logic [WIDTH-1:0] data;
    } word_t;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic [3:0]       gnt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;

    word_t            sb[$];
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       m_sel;
    int               n_checks;
    int               n_fail;

    arb_mux_4_1 #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic [3:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        #1;
    endtask

    // Push the word the expected grant should capture, take the edge, then update the slot model.
    task automatic clk_edge(input logic [3:0] eg);
        word_t w;
        logic  rdy;
        rdy = out_ready;
        if (eg != 4'b0000 && !rst) begin
            w.sel  = eg[1] ? 2'd1 : eg[2] ? 2'd2 : eg[3] ? 2'd3 : 2'd0;
            w.data = (w.sel == 2'd0) ? d0 : (w.sel == 2'd1) ? d1 : (w.sel == 2'd2) ? d2 : d3;
            sb.push_back(w);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 2'd0;
            sb.delete();
        end else if (eg != 4'b0000 && sb.size() > 0) begin
            w       = sb.pop_front();
            m_valid = 1'b1;
            m_data  = w.data;
            m_sel   = w.sel;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(4'b0000, 1'b1);
        clk_edge(4'b0000);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        rst = 1'b1;
        set_in(4'b1111, 1'b1);
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b, expected 0000", gnt);
        end
        clk_edge(4'b0000);
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 2'd0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b sel=%0d data=%h, expected v=0 sel=0 data=0",
                     out_valid, out_sel, out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] exp_dat[5] = '{4'ha, 4'hb, 4'hc, 4'hd, 4'ha};
        do_reset();
        d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
        for (int i = 0; i < 5; i++) begin
            set_in(4'b1111, 1'b1);
            n_checks++;
            if (gnt !== exp_gnt[i]) begin
                n_fail++;
                $display("FAIL rr_gnt[%0d]: got %b, expected %b", i, gnt, exp_gnt[i]);
            end
            clk_edge(exp_gnt[i]);
            n_checks++;
            if ({out_valid, out_sel, out_data} !== {1'b1, 2'(i % 4), exp_dat[i]} ||
                {out_valid, out_sel, out_data} !== {m_valid, m_sel, m_data}) begin
                n_fail++;
                $display("FAIL rr_out[%0d]: got v=%b sel=%0d data=%h, expected v=1 sel=%0d data=%h",
                         i, out_valid, out_sel, out_data, i % 4, exp_dat[i]);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] r[3]  = '{4'b0100, 4'b1010, 4'b1010};
        logic [3:0] eg[3] = '{4'b0100, 4'b1000, 4'b0010};
        do_reset();
        d0 = 4'h0; d1 = 4'h6; d2 = 4'h5; d3 = 4'he;
        for (int i = 0; i < 3; i++) begin
            set_in(r[i], 1'b1);
            n_checks++;
            if (gnt !== eg[i]) begin
                n_fail++;
                $display("FAIL rot_gnt[%0d]: got %b, expected %b", i, gnt, eg[i]);
            end
            clk_edge(eg[i]);
            n_checks++;
            if ({out_valid, out_sel, out_data} !== {m_valid, m_sel, m_data}) begin
                n_fail++;
                $display("FAIL rot_out[%0d]: got v=%b sel=%0d data=%h, expected v=%b sel=%0d data=%h",
                         i, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        d0 = 4'h7; d1 = 4'h3;
        set_in(4'b0001, 1'b1);
        clk_edge(4'b0001);
        for (int i = 0; i < 4; i++) begin
            logic rdy;
            logic [3:0] eg;
            rdy = (i == 3);
            eg  = rdy ? 4'b0010 : 4'b0000;
            set_in(4'b0010, rdy);
            n_checks++;
            if (gnt !== eg) begin
                n_fail++;
                $display("FAIL stall_gnt[%0d]: got %b, expected %b", i, gnt, eg);
            end
            clk_edge(eg);
            n_checks++;
            if ({out_valid, out_sel, out_data} !== {m_valid, m_sel, m_data} ||
                out_data !== (rdy ? 4'h3 : 4'h7)) begin
                n_fail++;
                $display("FAIL stall_out[%0d]: got v=%b sel=%0d data=%h, expected v=%b sel=%0d data=%h",
                         i, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
            end
        end
    endtask

    task automatic test_drain();
        do_reset();
        d0 = 4'h1; d3 = 4'h9;
        set_in(4'b1000, 1'b1);
        clk_edge(4'b1000);
        set_in(4'b0000, 1'b1);
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL drain_gnt: got %b, expected 0000", gnt);
        end
        clk_edge(4'b0000);
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 2'd3, 4'h9}) begin
            n_fail++;
            $display("FAIL drain_out: got v=%b sel=%0d data=%h, expected v=0 sel=3 data=9",
                     out_valid, out_sel, out_data);
        end
        // Pointer wrapped from 3 to 0, so requester 0 must win against everyone.
        set_in(4'b1111, 1'b1);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_gnt: got %b, expected 0001", gnt);
        end
        clk_edge(4'b0001);
    endtask

    task automatic test_x_isolation();
        do_reset();
        d0 = 4'h7; d1 = 'x; d2 = 'x; d3 = 'x;
        set_in(4'b0001, 1'b1);
        clk_edge(4'b0001);
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 4'h7}) begin
            n_fail++;
            $display("FAIL x_iso: got v=%b sel=%0d data=%h, expected v=1 sel=0 data=7",
                     out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        d0 = 4'h5; d1 = 4'h6; d2 = 4'h7; d3 = 4'h8;
        set_in(4'b1111, 1'b1);
        clk_edge(4'b0001);
        set_in(4'b1111, 1'b1);
        clk_edge(4'b0010);
        rst = 1'b1;
        set_in(4'b1111, 1'b1);
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL mrst_gnt: got %b, expected 0000", gnt);
        end
        clk_edge(4'b0000);
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b0, 2'd0, 4'h0}) begin
            n_fail++;
            $display("FAIL mrst_out: got v=%b sel=%0d data=%h, expected v=0 sel=0 data=0",
                     out_valid, out_sel, out_data);
        end
        rst = 1'b0;
        set_in(4'b1111, 1'b1);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL mrst_first: got %b, expected 0001", gnt);
        end
        clk_edge(4'b0001);
        n_checks++;
        if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 4'h5}) begin
            n_fail++;
            $display("FAIL mrst_reload: got v=%b sel=%0d data=%h, expected v=1 sel=0 data=5",
                     out_valid, out_sel, out_data);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_sel     = 2'd0;
        rst       = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b1;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        test_reset();
        test_round_robin();
        test_rotation();
        test_stall();
        test_drain();
        test_x_isolation();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
